sram_req_ctl: RTL and testbench

//  Request front-end sitting directly upstream of the sram array block.

---
 rtl/sram_req_ctl_pkg.sv | 23 ++
 rtl/sram_req_ctl.sv | 116 +++++++++++
 tb/tb_sram_req_ctl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_req_ctl_pkg.sv
// Shared definitions for the sram request front-end: FSM state encodings,
// default geometry and a helper for sizing the read-latency counter.
package sram_req_ctl_pkg;

    // Two-bit state encoding, fixed so other blocks can decode it if needed.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    localparam int DEF_DATA_W = 256;
    localparam int DEF_ADDR_W = 23;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_RD_LAT = 1;

    // Counter must hold the value RD_LAT; never narrower than one bit.
    function automatic int rd_cnt_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/sram_req_ctl.sv
// Request front-end for the sram array: accepts one read/write at a time,
// drives registered sram controls, waits out the array read latency and
// returns exactly one response per request. Out-of-range addresses are
// answered with an error and never touch the array.
module sram_req_ctl
    import sram_req_ctl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_data_in,
    output logic              sram_write_en,
    input  logic [DATA_W-1:0] sram_data_out
);

    localparam int CNT_W = rd_cnt_width(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT);
    // One extra bit so DEPTH itself is representable even when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             addr_ok;

    // Full-width compare: no truncation, so all-ones and DEPTH are both rejected.
    assign addr_ok = ({1'b0, req_addr} < DEPTH_EXT);

    // Request FSM with latency counter; every output is a register updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            sram_address  <= '0;
            sram_data_in  <= '0;
            sram_write_en <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (!addr_ok) begin
                            // Bad address: answer immediately, array untouched.
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_valid <= 1'b1;
                            state_reg <= ST_RSP;
                        end else if (req_we) begin
                            sram_address  <= req_addr;
                            sram_data_in  <= req_wdata;
                            sram_write_en <= 1'b1;
                            state_reg     <= ST_WR;
                        end else begin
                            sram_address <= req_addr;
                            cnt_reg      <= '0;
                            state_reg    <= ST_RD;
                        end
                    end else begin
                        // Ready rises one edge after reset release or handshake.
                        req_ready <= 1'b1;
                    end
                end
                ST_WR: begin
                    // Write strobe lasts exactly one cycle.
                    sram_write_en <= 1'b0;
                    rsp_data      <= '0;
                    rsp_err       <= 1'b0;
                    rsp_valid     <= 1'b1;
                    state_reg     <= ST_RSP;
                end
                ST_RD: begin
                    if (cnt_reg == CNT_LAST) begin
                        rsp_data  <= sram_data_out;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state_reg <= ST_RSP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_RSP: begin
                    // Hold the response until the consumer takes it.
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    req_ready     <= 1'b0;
                    rsp_valid     <= 1'b0;
                    sram_write_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_req_ctl.sv
// Self-checking bench for sram_req_ctl: behavioural array model, reference
// memory, directed cases followed by randomized transactions.
module tb_sram_req_ctl;

    localparam int DATA_W = 256;
    localparam int ADDR_W = 23;
    localparam int DEPTH  = 32;
    localparam int RD_LAT = 1;
    localparam int IDX_W  = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic [ADDR_W-1:0] sram_address;
    logic [DATA_W-1:0] sram_data_in;
    logic              sram_write_en;
    logic [DATA_W-1:0] sram_data_out;

    always #5 clk = ~clk;

    sram_req_ctl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .sram_address (sram_address),
        .sram_data_in (sram_data_in),
        .sram_write_en(sram_write_en),
        .sram_data_out(sram_data_out)
    );

    // Array model: synchronous write, one-cycle registered read.
    logic [DATA_W-1:0] sram_mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (sram_write_en) sram_mem[sram_address[IDX_W-1:0]] <= sram_data_in;
        sram_data_out <= sram_mem[sram_address[IDX_W-1:0]];
    end

    // Reference contents as the requester sees them.
    logic [DATA_W-1:0] ref_mem [0:DEPTH-1];

    int checks = 0;
    int errors = 0;
    int wen_total = 0;
    int acc_total = 0;
    int rsp_total = 0;
    int txn_done = 0;
    int aborted = 0;

    always @(negedge clk) if (sram_write_en) wen_total++;

    always @(posedge clk) begin
        if (rst && req_valid && req_ready) acc_total++;
        if (rst && rsp_valid && rsp_ready) rsp_total++;
    end

    task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string where);
        check_val({where, "_req_ready"}, req_ready, 0);
        check_val({where, "_rsp_valid"}, rsp_valid, 0);
        check_val({where, "_rsp_data"},  rsp_data, 0);
        check_val({where, "_rsp_err"},   rsp_err, 0);
        check_val({where, "_sram_addr"}, sram_address, 0);
        check_val({where, "_sram_din"},  sram_data_in, 0);
        check_val({where, "_sram_wen"},  sram_write_en, 0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_hold_ready", req_ready, 0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_release_ready", req_ready, 1);
    endtask

    // Present a request and return once it has been accepted (just after E0).
    task automatic present_req(input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) check_val("accept_timeout", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = ADDR_W'($urandom);
        req_wdata = {8{$urandom}};
        check_val("req_ready_busy", req_ready, 0);
    endtask

    task automatic do_txn(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input int hold);
        logic              legal;
        logic [DATA_W-1:0] exp_data;
        int                exp_lat;
        int                n;
        int                wen0;
        legal    = (addr < DEPTH);
        exp_data = (!we && legal) ? ref_mem[addr[IDX_W-1:0]] : '0;
        exp_lat  = !legal ? 0 : (we ? 1 : RD_LAT + 1);
        wen0     = wen_total;
        present_req(we, addr, wdata);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("rsp_latency", n, exp_lat);
        check_val("rsp_data", rsp_data, exp_data);
        check_val("rsp_err", rsp_err, !legal);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_val("hold_valid", rsp_valid, 1);
            check_val("hold_data", rsp_data, exp_data);
            check_val("hold_err", rsp_err, !legal);
            check_val("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check_val("wen_pulses", wen_total - wen0, (we && legal) ? 1 : 0);
        check_val("post_rsp_valid", rsp_valid, 0);
        check_val("post_req_ready", req_ready, 1);
        if (we && legal) ref_mem[addr[IDX_W-1:0]] = wdata;
        txn_done++;
        $display("txn %0d we=%0d addr=%0h hold=%0d err=%0d lat=%0d data=%h",
                 txn_done, we, addr, hold, rsp_err, n, rsp_data[63:0]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] pat;
        logic [ADDR_W-1:0] a;
        int                sel;

        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        pat       = {4{64'h1122334455667788}};

        // Power-up reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("init");
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("init_release_ready", req_ready, 1);

        // Basic write then read-back
        do_txn(1'b1, 5, pat, 0);
        do_txn(1'b0, 5, '0, 0);

        // Top legal address and out-of-range neighbours
        do_txn(1'b1, 31, {8{32'hCAFEF00D}}, 1);
        do_txn(1'b0, 31, '0, 0);
        do_txn(1'b1, 32, {8{32'hDEADBEEF}}, 0);
        do_txn(1'b0, 32, '0, 2);
        do_txn(1'b1, '1, {8{32'hBAD0BAD0}}, 0);
        do_txn(1'b0, '1, '0, 0);
        do_txn(1'b0, 31, '0, 0);

        // Backpressure for seven cycles
        do_txn(1'b1, 7, {8{32'h0BADC0DE}}, 7);
        do_txn(1'b0, 7, '0, 7);

        // Reset while the write strobe is high: write must not land
        present_req(1'b1, 5, {8{32'h55AA55AA}});
        check_val("rmw_wen_high", sram_write_en, 1);
        #1 rst = 1'b0;
        #1;
        check_reset_outputs("rmw");
        aborted++;
        release_reset();
        do_txn(1'b0, 5, '0, 0);

        // Reset while a response is pending: it is discarded
        present_req(1'b0, 5, '0);
        repeat (3) @(posedge clk);
        #1;
        check_val("rmr_pending", rsp_valid, 1);
        #1 rst = 1'b0;
        #1;
        check_reset_outputs("rmr");
        aborted++;
        release_reset();

        // Sweep every word
        for (int i = 0; i < DEPTH; i++)
            do_txn(1'b1, ADDR_W'(i), DATA_W'(i * 32'h01010101), 0);
        for (int i = 0; i < DEPTH; i++)
            do_txn(1'b0, ADDR_W'(i), '0, 0);

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = ADDR_W'($urandom_range(0, DEPTH - 1));
            else if (sel == 7) a = ADDR_W'(DEPTH);
            else if (sel == 8) a = '1;
            else               a = ADDR_W'($urandom);
            do_txn(1'($urandom_range(0, 1)), a, {8{$urandom}}, $urandom_range(0, 3));
        end

        check_val("rsp_count", rsp_total, txn_done);
        check_val("acc_count", acc_total, txn_done + aborted);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
